ifetch_unit: RTL and testbench

//   Instruction fetch stage directly upstream of the decoder. Serves the decoder's fetch

---
 rtl/ifetch_unit.sv | 175 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch stage: direct-mapped one-instruction-per-entry cache in front of a
// byte-wide memory read port. Hits answer in one cycle; misses are filled byte by byte.
module ifetch_unit #(
  parameter int ICACHE_IDX_WIDTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  input  logic        if_enable,
  input  logic [31:0] if_addr,
  output logic        inst_ready,
  output logic        is_c,
  output logic [31:0] inst_val,
  output logic        ic_mem_req,
  output logic [31:0] ic_mem_addr,
  input  logic        ic_mem_valid,
  input  logic [7:0]  ic_mem_data
);

  localparam int ENTRIES = 1 << ICACHE_IDX_WIDTH;
  localparam int TAG_W   = 31 - ICACHE_IDX_WIDTH;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                      state_q, state_d;
  logic [1:0]                  cnt_q, cnt_d;
  logic [30:0]                 miss_hw_q, miss_hw_d;
  logic [31:0]                 mem_addr_q, mem_addr_d;
  logic                        req_q, req_d;
  logic [23:0]                 buf_q, buf_d;
  logic                        ready_q, ready_d;
  logic [31:0]                 inst_q, inst_d;
  logic                        is_c_q, is_c_d;
  logic [ENTRIES-1:0]          valid_q, valid_d;

  logic [TAG_W-1:0]            tag_q  [ENTRIES];
  logic [31:0]                 data_q [ENTRIES];
  logic                        c_q    [ENTRIES];

  logic [ICACHE_IDX_WIDTH-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]            req_tag, fill_tag;
  logic                        hit;
  logic                        fill_done;
  logic                        wr_en;
  logic [31:0]                 wr_data;
  logic                        wr_c;
  logic                        unused_if_bit0;

  // Requests are halfword aligned, so bit 0 never takes part in the lookup.
  assign unused_if_bit0 = if_addr[0];

  assign req_idx  = if_addr[ICACHE_IDX_WIDTH:1];
  assign req_tag  = if_addr[31:ICACHE_IDX_WIDTH+1];
  assign fill_idx = miss_hw_q[ICACHE_IDX_WIDTH-1:0];
  assign fill_tag = miss_hw_q[30:ICACHE_IDX_WIDTH];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    miss_hw_d  = miss_hw_q;
    mem_addr_d = mem_addr_q;
    req_d      = req_q;
    buf_d      = buf_q;
    ready_d    = 1'b0;
    inst_d     = inst_q;
    is_c_d     = is_c_q;
    valid_d    = valid_q;
    fill_done  = 1'b0;
    wr_en      = 1'b0;
    wr_data    = 32'h0;
    wr_c       = 1'b0;

    if (!rdy_in) begin
      ready_d = 1'b0;
    end else if (clear) begin
      // Abandon any partial fill; whatever is already in the cache stays.
      req_d   = 1'b0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (if_enable) begin
            if (hit) begin
              ready_d = 1'b1;
              inst_d  = data_q[req_idx];
              is_c_d  = c_q[req_idx];
            end else begin
              miss_hw_d  = if_addr[31:1];
              mem_addr_d = if_addr;
              cnt_d      = 2'd0;
              req_d      = 1'b1;
              state_d    = S_FILL;
            end
          end
        end
        S_FILL: begin
          if (ic_mem_valid) begin
            mem_addr_d = mem_addr_q + 32'd1;
            cnt_d      = cnt_q + 2'd1;
            case (cnt_q)
              2'd0: buf_d[7:0] = ic_mem_data;
              2'd1: begin
                // Low two bits of the first byte decide between 16- and 32-bit encodings.
                if (buf_q[1:0] != 2'b11) begin
                  fill_done = 1'b1;
                  wr_data   = {16'h0, ic_mem_data, buf_q[7:0]};
                  wr_c      = 1'b1;
                end else begin
                  buf_d[15:8] = ic_mem_data;
                end
              end
              2'd2: buf_d[23:16] = ic_mem_data;
              default: begin
                fill_done = 1'b1;
                wr_data   = {ic_mem_data, buf_q};
                wr_c      = 1'b0;
              end
            endcase
            if (fill_done) begin
              wr_en             = 1'b1;
              valid_d[fill_idx] = 1'b1;
              req_d             = 1'b0;
              state_d           = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      cnt_q      <= 2'd0;
      miss_hw_q  <= 31'h0;
      mem_addr_q <= 32'h0;
      req_q      <= 1'b0;
      buf_q      <= 24'h0;
      ready_q    <= 1'b0;
      inst_q     <= 32'h0;
      is_c_q     <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      miss_hw_q  <= miss_hw_d;
      mem_addr_q <= mem_addr_d;
      req_q      <= req_d;
      buf_q      <= buf_d;
      ready_q    <= ready_d;
      inst_q     <= inst_d;
      is_c_q     <= is_c_d;
      valid_q    <= valid_d;
    end
  end

  // Entry payload needs no reset: the valid bits alone qualify it.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= wr_data;
      c_q[fill_idx]    <= wr_c;
    end
  end

  assign inst_ready  = ready_q;
  assign is_c        = is_c_q;
  assign inst_val    = inst_q;
  assign ic_mem_req  = req_q;
  assign ic_mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed corner sequences, a vector table of hit/miss cycles, and
// randomized fetches checked against an address-level cache model over a static memory image.
module tb_ifetch_unit;

  logic        clk_in, rst_in, rdy_in, clear, if_enable;
  logic [31:0] if_addr;
  logic        inst_ready, is_c;
  logic [31:0] inst_val;
  logic        ic_mem_req;
  logic [31:0] ic_mem_addr;
  logic        ic_mem_valid;
  logic [7:0]  ic_mem_data;

  ifetch_unit #(.ICACHE_IDX_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .if_enable(if_enable), .if_addr(if_addr),
    .inst_ready(inst_ready), .is_c(is_c), .inst_val(inst_val),
    .ic_mem_req(ic_mem_req), .ic_mem_addr(ic_mem_addr),
    .ic_mem_valid(ic_mem_valid), .ic_mem_data(ic_mem_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_pct  = 100;
  bit          last_consumed;
  logic [31:0] last_addr;
  logic [31:0] exp_val_last;
  logic        exp_c_last;

  // Model: which halfword address each of the 16 sets currently holds.
  bit          m_valid [16];
  logic [31:0] m_addr  [16];

  typedef struct {
    bit          en;
    logic [31:0] addr;
    bit          exp_rdy;
    logic [31:0] exp_val;
    bit          exp_c;
    bit          exp_req;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:         return 8'h13;
      32'h1:         return 8'h05;
      32'h2:         return 8'h00;
      32'h3:         return 8'h00;
      32'h4:         return 8'h05;
      32'h5:         return 8'h45;
      32'h6:         return 8'h82;
      32'h7:         return 8'h80;
      32'h20:        return 8'h93;
      32'h21:        return 8'h00;
      32'h22:        return 8'h10;
      32'h23:        return 8'h00;
      32'h40:        return 8'h6f;
      32'h41:        return 8'h00;
      32'h42:        return 8'h00;
      32'h43:        return 8'h00;
      32'hFFFF_FFFE: return 8'h37;
      32'hFFFF_FFFF: return 8'h12;
      default:       return 8'(a[7:0] * 8'd29) ^ a[15:8] ^ {a[31:28], 4'h5};
    endcase
  endfunction

  function automatic int ref_len(input logic [31:0] a);
    logic [7:0] b0;
    b0 = mem_byte(a);
    return (b0[1:0] == 2'b11) ? 4 : 2;
  endfunction

  function automatic logic [31:0] ref_inst(input logic [31:0] a);
    if (ref_len(a) == 2)
      return {16'h0, mem_byte(a + 32'd1), mem_byte(a)};
    return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[4:1]] && (m_addr[a[4:1]] == a);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_valid[a[4:1]] = 1'b1;
    m_addr[a[4:1]]  = a;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    if (ic_mem_req && ($urandom_range(0, 99) < mem_pct)) begin
      ic_mem_valid = 1'b1;
      ic_mem_data  = mem_byte(ic_mem_addr);
    end else begin
      ic_mem_valid = 1'b0;
      ic_mem_data  = 8'($urandom);
    end
    last_consumed = ic_mem_valid && rdy_in && !clear && ic_mem_req;
    last_addr     = ic_mem_addr;
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    if_enable = 1'b0;
    clear     = 1'b0;
    rdy_in    = 1'b1;
    rst_in    = 1'b1;
    #2;
    chk("rst_ready", 32'(inst_ready), 32'd0);
    chk("rst_is_c", 32'(is_c), 32'd0);
    chk("rst_val", inst_val, 32'h0);
    chk("rst_req", 32'(ic_mem_req), 32'd0);
    chk("rst_addr", ic_mem_addr, 32'h0);
    tick();
    tick();
    rst_in = 1'b0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    exp_val_last = 32'h0;
    exp_c_last   = 1'b0;
  endtask

  // Fill already in progress for address a with n0 bytes consumed; finish it and look it up.
  task automatic finish_fill(input logic [31:0] a, input int n0, input bit rand_rdy);
    int n;
    int budget;
    n      = n0;
    budget = 400;
    while (ic_mem_req && budget > 0) begin
      rdy_in = rand_rdy ? ($urandom_range(0, 7) != 0) : 1'b1;
      tick();
      if (last_consumed) begin
        chk("fill_addr", last_addr, a + 32'(n));
        n++;
      end
      chk("fill_no_ready", 32'(inst_ready), 32'd0);
      budget--;
    end
    if (budget == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL fill_timeout: got req still high, expected fill end at %h", a);
    end
    chk("fill_len", 32'(n), 32'(ref_len(a)));
    rdy_in = 1'b1;
    tick();
    exp_val_last = ref_inst(a);
    exp_c_last   = (ref_len(a) == 2);
    chk("post_fill_ready", 32'(inst_ready), 32'd1);
    chk("post_fill_val", inst_val, exp_val_last);
    chk("post_fill_c", 32'(is_c), 32'(exp_c_last));
    model_fill(a);
  endtask

  task automatic fetch(input logic [31:0] a, input bit rand_rdy);
    bit h;
    h         = model_hit(a);
    if_enable = 1'b1;
    if_addr   = a;
    rdy_in    = 1'b1;
    tick();
    if (h) begin
      exp_val_last = ref_inst(a);
      exp_c_last   = (ref_len(a) == 2);
      chk("hit_ready", 32'(inst_ready), 32'd1);
      chk("hit_val", inst_val, exp_val_last);
      chk("hit_c", 32'(is_c), 32'(exp_c_last));
      chk("hit_no_req", 32'(ic_mem_req), 32'd0);
    end else begin
      chk("miss_ready", 32'(inst_ready), 32'd0);
      chk("miss_req", 32'(ic_mem_req), 32'd1);
      chk("miss_addr", ic_mem_addr, a);
      finish_fill(a, 0, rand_rdy);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 32'h4, 1'b1, 32'h0000_4505, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 32'h6, 1'b1, 32'h0000_8082, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 32'h0, 1'b0, 32'h0000_8082, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 32'h6, 1'b1, 32'h0000_8082, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h0, 1'b1, 32'h0000_0513, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 32'h2, 1'b0, 32'h0000_0513, 1'b0, 1'b1};

    rst_in = 1'b0; rdy_in = 1'b1; clear = 1'b0; if_enable = 1'b0; if_addr = 32'h0;
    ic_mem_valid = 1'b0; ic_mem_data = 8'h0;
    last_consumed = 1'b0; last_addr = 32'h0;
    #3;
    do_reset();

    // Reset between bytes of a fill.
    if_enable = 1'b1; if_addr = 32'h0;
    tick();
    chk("t1_req", 32'(ic_mem_req), 32'd1);
    tick();
    tick();
    chk("t1_mid_addr", ic_mem_addr, 32'h2);
    rst_in = 1'b1;
    #1;
    chk("t1_async_req", 32'(ic_mem_req), 32'd0);
    chk("t1_async_ready", 32'(inst_ready), 32'd0);
    if_enable = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    chk("t1_no_ready", 32'(inst_ready), 32'd0);
    if_enable = 1'b1;
    tick();
    chk("t1_miss_again", 32'(ic_mem_req), 32'd1);
    chk("t1_miss_addr", ic_mem_addr, 32'h0);
    do_reset();

    // Cold 32-bit fetch at 0x0: exact latency.
    if_enable = 1'b1; if_addr = 32'h0;
    tick();
    chk("t2_req", 32'(ic_mem_req), 32'd1);
    chk("t2_addr0", ic_mem_addr, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("t2_no_ready", 32'(inst_ready), 32'd0);
      chk("t2_req_k", 32'(ic_mem_req), 32'(k < 4));
      if (k < 4) chk("t2_addr_k", ic_mem_addr, 32'(k));
    end
    tick();
    chk("t2_ready", 32'(inst_ready), 32'd1);
    chk("t2_val", inst_val, 32'h0000_0513);
    chk("t2_c", 32'(is_c), 32'd0);
    tick();
    chk("t2_rehit", 32'(inst_ready), 32'd1);
    chk("t2_rehit_val", inst_val, 32'h0000_0513);
    model_fill(32'h0);

    // Cold compressed fetch at 0x4.
    if_addr = 32'h4;
    tick();
    chk("t3_req", 32'(ic_mem_req), 32'd1);
    chk("t3_addr", ic_mem_addr, 32'h4);
    chk("t3_no_ready", 32'(inst_ready), 32'd0);
    tick();
    chk("t3_addr1", ic_mem_addr, 32'h5);
    tick();
    chk("t3_req_done", 32'(ic_mem_req), 32'd0);
    chk("t3_no_ready2", 32'(inst_ready), 32'd0);
    tick();
    chk("t3_ready", 32'(inst_ready), 32'd1);
    chk("t3_val", inst_val, 32'h0000_4505);
    chk("t3_c", 32'(is_c), 32'd1);
    model_fill(32'h4);

    fetch(32'h6, 1'b0);

    // Back-to-back hits and one miss, vector table.
    for (int i = 0; i < 7; i++) begin
      if_enable = vecs[i].en;
      if_addr   = vecs[i].addr;
      tick();
      chk("vec_ready", 32'(inst_ready), 32'(vecs[i].exp_rdy));
      chk("vec_val", inst_val, vecs[i].exp_val);
      chk("vec_c", 32'(is_c), 32'(vecs[i].exp_c));
      chk("vec_req", 32'(ic_mem_req), 32'(vecs[i].exp_req));
    end
    exp_val_last = 32'h0000_0513;
    finish_fill(32'h2, 0, 1'b0);

    // clear together with the last byte of a fill at 0x40.
    if_enable = 1'b1; if_addr = 32'h40;
    tick();
    chk("t5_req", 32'(ic_mem_req), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_req_hold", 32'(ic_mem_req), 32'd1);
    end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clear_req", 32'(ic_mem_req), 32'd0);
    chk("t5_clear_ready", 32'(inst_ready), 32'd0);
    tick();
    chk("t5_remiss", 32'(ic_mem_req), 32'd1);
    chk("t5_remiss_addr", ic_mem_addr, 32'h40);
    finish_fill(32'h40, 0, 1'b0);

    // rdy_in low across a hit response and across a fill.
    if_addr = 32'h4;
    rdy_in  = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_hit_stall", 32'(inst_ready), 32'd0);
      chk("t6_val_hold", inst_val, 32'h0000_006f);
    end
    rdy_in = 1'b1;
    tick();
    chk("t6_hit_ready", 32'(inst_ready), 32'd1);
    chk("t6_hit_val", inst_val, 32'h0000_4505);
    if_addr = 32'h20;
    tick();
    chk("t6_req", 32'(ic_mem_req), 32'd1);
    tick();
    tick();
    chk("t6_addr2", ic_mem_addr, 32'h22);
    rdy_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t6_fill_req", 32'(ic_mem_req), 32'd1);
      chk("t6_fill_addr", ic_mem_addr, 32'h22);
      chk("t6_fill_ready", 32'(inst_ready), 32'd0);
    end
    rdy_in = 1'b1;
    finish_fill(32'h20, 2, 1'b0);
    chk("t6_val20", inst_val, 32'h0010_0093);
    fetch(32'h0, 1'b0);
    fetch(32'h20, 1'b0);
    fetch(32'h40, 1'b0);
    fetch(32'hFFFF_FFFE, 1'b0);
    chk("wrap_val", inst_val, 32'h0513_1237);

    // Randomized fetches against the set model.
    do_reset();
    mem_pct = 70;
    for (int it = 0; it < 250; it++) begin
      logic [31:0] a;
      int          k;
      a = (32'($urandom_range(0, 31)) << 1) | (32'($urandom_range(0, 1)) << 28);
      if ($urandom_range(0, 3) == 0) begin
        if_enable = 1'b0;
        rdy_in    = 1'b1;
        tick();
        chk("rnd_idle_ready", 32'(inst_ready), 32'd0);
        chk("rnd_idle_val", inst_val, exp_val_last);
      end
      k         = $urandom_range(0, 2);
      if_enable = 1'b1;
      if_addr   = a;
      rdy_in    = 1'b0;
      for (int j = 0; j < k; j++) begin
        tick();
        chk("rnd_stall_ready", 32'(inst_ready), 32'd0);
        chk("rnd_stall_req", 32'(ic_mem_req), 32'd0);
      end
      fetch(a, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
